// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// The optional overflow output is controlled by PIPE_ADDER_OVF_EN.
package adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG   = 8;

   function automatic int stages_of(input int width, input int seg);
      return width / seg;
   endfunction

   // Legal configurations split the operand into whole segments.
   function automatic bit width_ok(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bundle for pipe_adder. The ovf signal exists only when
// PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
   parameter int WIDTH = 32
);
   // Each side transfers a beat on a cycle where valid && ready are both high.
   // A valid producer holds its beat stable until that transfer happens.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, ci, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, s, co
   );

   modport slave (
      input  in_valid, a, b, ci, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, s, co
   );

endinterface

// File: rtl/seg_adder.sv
// SEG-bit combinational bit-ripple adder; one instance per pipe_adder stage.
module seg_adder #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   logic [SEG:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined adder, one SEG-bit slice added per stage.
// Define PIPE_ADDER_OVF_EN to add a registered signed-overflow output (io.ovf).
module pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic       clk,
   input  logic       rst_n,
   pipe_adder_if.slave io
);

   localparam int STAGES = stages_of(WIDTH, SEG);
   localparam int LAST   = STAGES - 1;

   if (!width_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a positive multiple of SEG");
   end

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] cy;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] cin;
   logic              rdy;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  in_a  [STAGES];
   logic [WIDTH-1:0]  in_b  [STAGES];
   logic [WIDTH-1:0]  sum_n [STAGES];
   logic [SEG-1:0]    op_a  [STAGES];
   logic [SEG-1:0]    op_b  [STAGES];
   logic [SEG-1:0]    seg_s [STAGES];
   logic              seg_c [STAGES];

   // Stall chain runs from the output back to the input, so in_ready is
   // combinational from out_ready and a full pipeline can pop and fill together.
   always_comb begin
      adv       = '0;
      load      = '0;
      adv[LAST] = vld[LAST] && io.out_ready;
      for (int k = LAST - 1; k >= 0; k--) begin
         adv[k] = vld[k] && (!vld[k+1] || adv[k+1]);
      end
      rdy     = !vld[0] || adv[0];
      load[0] = io.in_valid && rdy;
      for (int k = 1; k < STAGES; k++) begin
         load[k] = adv[k-1];
      end
   end

   assign io.in_ready = rdy;

   always_comb begin
      in_a[0] = io.a;
      in_b[0] = io.b;
      cin[0]  = io.ci;
      for (int k = 1; k < STAGES; k++) begin
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
         cin[k]  = cy[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         op_a[k] = in_a[k][k*SEG +: SEG];
         op_b[k] = in_b[k][k*SEG +: SEG];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      seg_adder #(.SEG(SEG)) u_add (
         .a  (op_a[k]),
         .b  (op_b[k]),
         .ci (cin[k]),
         .s  (seg_s[k]),
         .co (seg_c[k])
      );
   end

   // Each stage keeps the lower sum segments from upstream and inserts its own.
   always_comb begin
      sum_n[0]          = '0;
      sum_n[0][SEG-1:0] = seg_s[0];
      for (int k = 1; k < STAGES; k++) begin
         sum_n[k]                = sum_q[k-1];
         sum_n[k][k*SEG +: SEG]  = seg_s[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         cy  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               vld[k]   <= 1'b1;
               cy[k]    <= seg_c[k];
               sum_q[k] <= sum_n[k];
               a_q[k]   <= in_a[k];
               b_q[k]   <= in_b[k];
            end else if (adv[k]) begin
               vld[k] <= 1'b0;
            end
         end
      end
   end

   assign io.out_valid = vld[LAST];
   assign io.s         = sum_q[LAST];
   assign io.co        = cy[LAST];

`ifdef PIPE_ADDER_OVF_EN
   logic msb_c;
   logic msb_c_q;

   // Carry into the top bit, recovered from the final slice's sum bit.
   assign msb_c = seg_s[LAST][SEG-1] ^ op_a[LAST][SEG-1] ^ op_b[LAST][SEG-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msb_c_q <= 1'b0;
      end else if (load[LAST]) begin
         msb_c_q <= msb_c;
      end
   end

   assign io.ovf = msb_c_q ^ cy[LAST];
`endif

endmodule
